cic_interpolator: RTL and testbench

- 3-stage CIC interpolation filter: interpolation rate R=32, differential delay D=2; the transmit-side counterpart of the team's CIC decimator.
- Accepts low-rate signed samples through a valid/ready handshake, once per 32 clocks.
- Emits one signed high-rate sample every clock.
- Comb section runs at the input rate. Zero-stuffing and the integrator section run at cic_clk.

---
 rtl/cic_interpolator.sv | 93 +++++++++
 tb/tb_cic_interpolator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// 3-stage CIC interpolator, R=32, D=2.
// Combs run at the input rate; zero-stuff and integrators run every clock.
module cic_interpolator #(
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 16,
  parameter int ACC_W  = 29
) (
  input  logic              cic_clk,
  input  logic              cic_rstn,
  input  logic [DIN_W-1:0]  cic_din,
  input  logic              cic_din_vld,
  output logic              cic_din_rdy,
  output logic [DOUT_W-1:0] cic_dout,
  output logic              cic_underrun
);

  logic             run;
  logic [4:0]       phase;
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] c1, c2, c3;
  logic [ACC_W-1:0] x_d1, x_d2;
  logic [ACC_W-1:0] c1_d1, c1_d2;
  logic [ACC_W-1:0] c2_d1, c2_d2;
  logic [ACC_W-1:0] comb_out;
  logic [ACC_W-1:0] int_in;
  logic [ACC_W-1:0] int0, int1, int2;
  logic             unused_lsb;

  assign cic_din_rdy = (phase == 5'd31);

  // A missed slot feeds a zero so the comb history stays aligned.
  assign x = cic_din_vld
    ? {{(ACC_W-DIN_W){cic_din[DIN_W-1]}}, cic_din}
    : '0;

  assign c1 = x - x_d2;
  assign c2 = c1 - c1_d2;
  assign c3 = c2 - c2_d2;

  assign int_in = (phase == 5'd0) ? comb_out : '0;

  assign unused_lsb = ^int2[ACC_W-DOUT_W-1:0];

  // run holds phase at 0 for the first edge after reset release.
  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) begin
      run   <= 1'b0;
      phase <= '0;
    end else begin
      run   <= 1'b1;
      phase <= run ? phase + 5'd1 : 5'd0;
    end
  end

  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) begin
      x_d1         <= '0;
      x_d2         <= '0;
      c1_d1        <= '0;
      c1_d2        <= '0;
      c2_d1        <= '0;
      c2_d2        <= '0;
      comb_out     <= '0;
      cic_underrun <= 1'b0;
    end else begin
      cic_underrun <= cic_din_rdy & ~cic_din_vld;
      if (cic_din_rdy) begin
        x_d1     <= x;
        x_d2     <= x_d1;
        c1_d1    <= c1;
        c1_d2    <= c1_d1;
        c2_d1    <= c2;
        c2_d2    <= c2_d1;
        comb_out <= c3;
      end
    end
  end

  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) begin
      int0     <= '0;
      int1     <= '0;
      int2     <= '0;
      cic_dout <= '0;
    end else begin
      int0     <= int0 + int_in;
      int1     <= int1 + int0;
      int2     <= int2 + int1;
      cic_dout <= int2[ACC_W-1 -: DOUT_W];
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator.
// Table vectors for impulse and DC; hand sequences for reset/underrun.
module tb_cic_interpolator;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic signed [15:0] din = '0;
  logic               vld = 1'b0;
  logic               rdy;
  logic signed [15:0] dout;
  logic               und;

  int nvec = 0;
  int nerr = 0;
  int accepts = 0;
  int unds = 0;

  typedef struct {
    int                 off;
    logic signed [15:0] exp;
  } imp_t;

  typedef struct {
    logic signed [15:0] din;
    logic signed [15:0] exp;
  } dc_t;

  imp_t imp[8];
  dc_t  dc[3];

  cic_interpolator dut (
    .cic_clk      (clk),
    .cic_rstn     (rstn),
    .cic_din      (din),
    .cic_din_vld  (vld),
    .cic_din_rdy  (rdy),
    .cic_dout     (dout),
    .cic_underrun (und)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    if (rdy && vld) accepts++;
    @(posedge clk);
    #1;
    if (und) unds++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 64 && !rdy; i++) tick();
    chk("rdy_timeout", rdy, 1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_und", und, 0);
    @(posedge clk);
    #4;
    rstn = 1'b1;
  endtask

  // Leaves the bench at edge T+8 of the accepted impulse.
  task automatic run_impulse(input string tag);
    wait_rdy();
    din = 16'sd8192;
    vld = 1'b1;
    tick();
    din = '0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_t%0d", tag, imp[i].off), dout, imp[i].exp);
      tick();
    end
  endtask

  task automatic hold_check(input string name,
                            input logic signed [15:0] exp,
                            input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (dout !== exp) bad++;
      tick();
    end
    chk(name, bad, 0);
  endtask

  initial begin
    int lo;
    int seen_nz;

    imp[0] = '{0, 16'sd0};
    imp[1] = '{1, 16'sd0};
    imp[2] = '{2, 16'sd0};
    imp[3] = '{3, 16'sd0};
    imp[4] = '{4, 16'sd1};
    imp[5] = '{5, 16'sd3};
    imp[6] = '{6, 16'sd6};
    imp[7] = '{7, 16'sd10};
    dc[0] = '{16'sd1000, 16'sd1000};
    dc[1] = '{-16'sd32768, -16'sd32768};
    dc[2] = '{16'sd32767, 16'sd32767};

    // Reset state, first rdy at edge 32, one accept per 32 clocks.
    #2;
    do_reset();
    vld = 1'b1;
    din = '0;
    accepts = 0;
    lo = 0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (rdy) lo++;
    end
    chk("rdy_early", lo, 0);
    tick();
    chk("rdy_edge32", rdy, 1);
    tick();
    chk("rdy_edge33", rdy, 0);
    ticks(30);
    chk("rdy_edge63", rdy, 0);
    tick();
    chk("rdy_edge64", rdy, 1);
    ticks(321 - 64);
    chk("accepts_321", accepts, 10);

    // Impulse response and decay.
    run_impulse("imp");
    ticks(192);
    hold_check("imp_tail", 16'sd0, 64);

    // Reset during an impulse response.
    run_impulse("imp2");
    ticks(2);
    chk("pre_rst_nz", (dout != 0), 1);
    do_reset();
    vld = 1'b1;
    din = '0;
    hold_check("post_rst_zero", 16'sd0, 40);
    run_impulse("imp3");

    // DC levels, each settling within 200 clocks of its first accept.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_rdy();
      din = dc[i].din;
      vld = 1'b1;
      ticks(200);
      hold_check($sformatf("dc_%0d", dc[i].exp), dc[i].exp, 96);
    end

    // Underrun after DC 1000 has settled.
    wait_rdy();
    din = 16'sd1000;
    ticks(200);
    unds = 0;
    hold_check("dc_pre_und", 16'sd1000, 40);
    chk("und_spurious", unds, 0);
    wait_rdy();
    vld = 1'b0;
    tick();
    chk("und_pulse", und, 1);
    vld = 1'b1;
    tick();
    chk("und_one_clk", und, 0);
    seen_nz = 0;
    for (int i = 0; i < 200; i++) begin
      if (dout != 16'sd1000) seen_nz = 1;
      tick();
    end
    chk("und_deviates", seen_nz, 1);
    ticks(60);
    hold_check("und_recover", 16'sd1000, 96);
    chk("und_count", unds, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
